// File: rtl/vga_pkg.sv
// Shared VGA timing constants and elaboration-time helpers for the timing core.
package vga_pkg;

    localparam int unsigned XGA_H_ACTIVE = 1024;
    localparam int unsigned XGA_H_FRONT  = 24;
    localparam int unsigned XGA_H_SYNC   = 136;
    localparam int unsigned XGA_H_BACK   = 160;
    localparam int unsigned XGA_V_ACTIVE = 768;
    localparam int unsigned XGA_V_FRONT  = 3;
    localparam int unsigned XGA_V_SYNC   = 6;
    localparam int unsigned XGA_V_BACK   = 29;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;

    typedef struct packed {
        logic active;
        logic h_sync;
        logic v_sync;
    } vga_flags_t;

    // Never returns 0, so a degenerate size still yields a legal vector width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with synchronous clear; depth 0 is a wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_reset, i_en};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing: pixel/line counters, pixel request strobe and a
// latency-matched, registered colour/sync output stage.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned H_ACTIVE    = XGA_H_ACTIVE,
    parameter int unsigned H_FRONT     = XGA_H_FRONT,
    parameter int unsigned H_SYNC      = XGA_H_SYNC,
    parameter int unsigned H_BACK      = XGA_H_BACK,
    parameter int unsigned V_ACTIVE    = XGA_V_ACTIVE,
    parameter int unsigned V_FRONT     = XGA_V_FRONT,
    parameter int unsigned V_SYNC      = XGA_V_SYNC,
    parameter int unsigned V_BACK      = XGA_V_BACK,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned PIPE_LAT    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [COLOR_DEPTH-1:0]        vga_r_in,
    input  logic [COLOR_DEPTH-1:0]        vga_g_in,
    input  logic [COLOR_DEPTH-1:0]        vga_b_in,
    output logic [clog2(H_ACTIVE)-1:0]    pixel_x,
    output logic [clog2(V_ACTIVE)-1:0]    pixel_y,
    output logic                          pixel_req,
    output logic                          frame_start,
    output logic [COLOR_DEPTH-1:0]        vga_r_out,
    output logic [COLOR_DEPTH-1:0]        vga_g_out,
    output logic [COLOR_DEPTH-1:0]        vga_b_out,
    output logic                          vga_hs,
    output logic                          vga_vs,
    output logic                          vga_blank_n,
    output logic                          vga_sync_n,
    output logic                          vga_clk
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = clog2(H_TOTAL);
    localparam int unsigned VW      = clog2(V_TOTAL);
    localparam int unsigned XW      = clog2(H_ACTIVE);
    localparam int unsigned YW      = clog2(V_ACTIVE);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END  = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END  = V_ACTIVE + V_FRONT + V_SYNC;

    logic [HW-1:0]          r_h_ctr;
    logic [VW-1:0]          r_v_ctr;
    logic                   w_h_last;
    logic                   w_v_last;
    vga_flags_t             w_flags;
    vga_flags_t             w_flags_d;
    logic [COLOR_DEPTH-1:0] r_r;
    logic [COLOR_DEPTH-1:0] r_g;
    logic [COLOR_DEPTH-1:0] r_b;
    logic                   r_hs;
    logic                   r_vs;
    logic                   r_blank_n;

    // Comparisons are done at 32 bits so a sync window ending exactly at
    // TOTAL cannot alias when TOTAL is a power of two.
    assign w_h_last = (32'(r_h_ctr) == H_TOTAL - 1);
    assign w_v_last = (32'(r_v_ctr) == V_TOTAL - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_ctr <= '0;
            r_v_ctr <= '0;
        end else if (clk_en) begin
            if (w_h_last) begin
                r_h_ctr <= '0;
                r_v_ctr <= w_v_last ? '0 : r_v_ctr + VW'(1);
            end else begin
                r_h_ctr <= r_h_ctr + HW'(1);
            end
        end
    end

    always_comb begin
        w_flags        = '0;
        w_flags.active = (32'(r_h_ctr) < H_ACTIVE) && (32'(r_v_ctr) < V_ACTIVE);
        w_flags.h_sync = (32'(r_h_ctr) >= HS_BEG) && (32'(r_h_ctr) < HS_END);
        w_flags.v_sync = (32'(r_v_ctr) >= VS_BEG) && (32'(r_v_ctr) < VS_END);
    end

    assign pixel_req   = w_flags.active;
    assign pixel_x     = w_flags.active ? r_h_ctr[XW-1:0] : '0;
    assign pixel_y     = w_flags.active ? r_v_ctr[YW-1:0] : '0;
    assign frame_start = clk_en && (r_h_ctr == '0) && (r_v_ctr == '0);

    vga_delay_line #(
        .WIDTH ($bits(vga_flags_t)),
        .DEPTH (PIPE_LAT)
    ) u_flag_delay (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (clk_en),
        .i_d     (w_flags),
        .o_q     (w_flags_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_blank_n <= 1'b0;
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
        end else if (clk_en) begin
            r_r       <= w_flags_d.active ? vga_r_in : '0;
            r_g       <= w_flags_d.active ? vga_g_in : '0;
            r_b       <= w_flags_d.active ? vga_b_in : '0;
            r_blank_n <= w_flags_d.active;
            r_hs      <= w_flags_d.h_sync ? HS_POL : ~HS_POL;
            r_vs      <= w_flags_d.v_sync ? VS_POL : ~VS_POL;
        end
    end

    assign vga_r_out   = r_r;
    assign vga_g_out   = r_g;
    assign vga_b_out   = r_b;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b1;
    assign vga_clk     = clk;

endmodule
